// File: rtl/wb_master_cmd_if.sv
// wb_master_cmd_if: bundles the command stream, the response stream and the
// Wishbone pipelined-mode bus of the wb_master_cmd initiator.
//   master modport : the initiator (accepts commands, drives Wishbone, returns responses)
//   slave  modport : the environment (command source, response sink, Wishbone target)
// Signal suffixes (_i/_o) are named from the initiator's point of view.
interface wb_master_cmd_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    // command stream
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_we_i;
    logic [ADDR_W-1:0] cmd_adr_i;
    logic [DATA_W-1:0] cmd_dat_i;
    logic [SEL_W-1:0]  cmd_sel_i;
    // response stream
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_dat_o;
    logic [1:0]        rsp_status_o;
    // Wishbone
    logic [ADDR_W-1:0] wb_adr_o;
    logic [DATA_W-1:0] wb_dat_o;
    logic [SEL_W-1:0]  wb_sel_o;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic [DATA_W-1:0] wb_dat_i;
    logic              wb_ack_i;
    logic              wb_err_i;
    logic              wb_rty_i;
    logic              wb_stall_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_status_o,
        input  rsp_ready_i,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_status_o,
        output rsp_ready_i,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i
    );
endinterface

// File: rtl/wb_master_cmd.sv
// wb_master_cmd: single-outstanding Wishbone pipelined-mode initiator.
// Turns one valid/ready command into one Wishbone cycle, handling stall,
// ack, err and rty (bounded re-issue), with a per-attempt timeout watchdog,
// and returns the outcome on a valid/ready response stream.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   bus    : wb_master_cmd_if.master (command in, response out, Wishbone)
// Response status: 00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT.
// All outputs come straight from flops.
module wb_master_cmd #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    wb_master_cmd_if.master      bus
);
    localparam int SEL_W = DATA_W / 8;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    // Last counter value before the limit: the cycle in which the count
    // would reach TIMEOUT_CYCLES.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_ERR  = 2'b01;
    localparam logic [1:0] ST_EXH  = 2'b10;
    localparam logic [1:0] ST_TMO  = 2'b11;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, BACKOFF, RESP} state_t;

    state_t            state_q, state_d;
    logic [RTY_W-1:0]  rty_cnt_q, rty_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic [ADDR_W-1:0] wb_adr_q, wb_adr_d;
    logic [DATA_W-1:0] wb_dat_q, wb_dat_d;
    logic [SEL_W-1:0]  wb_sel_q, wb_sel_d;
    logic              wb_we_q, wb_we_d;
    logic              wb_cyc_q, wb_cyc_d;
    logic              wb_stb_q, wb_stb_d;
    logic              tmo_hit;

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d      = state_q;
        rty_cnt_d    = rty_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        wb_adr_d     = wb_adr_q;
        wb_dat_d     = wb_dat_q;
        wb_sel_d     = wb_sel_q;
        wb_we_d      = wb_we_q;

        case (state_q)
            IDLE: begin
                // cmd_ready_q (not the state) gates acceptance so nothing is
                // taken in the first cycle after reset release.
                if (bus.cmd_valid_i && cmd_ready_q) begin
                    wb_adr_d  = bus.cmd_adr_i;
                    wb_dat_d  = bus.cmd_dat_i;
                    wb_sel_d  = bus.cmd_sel_i;
                    wb_we_d   = bus.cmd_we_i;
                    rty_cnt_d = '0;
                    tmo_cnt_d = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // Terminations are not meaningful before the strobe is taken.
                if (tmo_hit) begin
                    rsp_status_d = ST_TMO;
                    rsp_dat_d    = '0;
                    state_d      = RESP;
                end else begin
                    if (TIMEOUT_CYCLES != 0) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (!bus.wb_stall_i) state_d = WAIT;
                end
            end
            WAIT: begin
                // err > rty > ack; any termination beats the watchdog.
                if (bus.wb_err_i) begin
                    rsp_status_d = ST_ERR;
                    rsp_dat_d    = '0;
                    state_d      = RESP;
                end else if (bus.wb_rty_i) begin
                    if (rty_cnt_q == RTY_MAX) begin
                        rsp_status_d = ST_EXH;
                        rsp_dat_d    = '0;
                        state_d      = RESP;
                    end else begin
                        rty_cnt_d = rty_cnt_q + RTY_W'(1);
                        state_d   = BACKOFF;
                    end
                end else if (bus.wb_ack_i) begin
                    rsp_status_d = ST_OK;
                    rsp_dat_d    = wb_we_q ? '0 : bus.wb_dat_i;
                    state_d      = RESP;
                end else if (tmo_hit) begin
                    rsp_status_d = ST_TMO;
                    rsp_dat_d    = '0;
                    state_d      = RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            BACKOFF: begin
                // Each attempt gets a fresh watchdog budget.
                tmo_cnt_d = '0;
                state_d   = REQ;
            end
            RESP: begin
                if (bus.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with it.
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        wb_cyc_d    = (state_d == REQ) || (state_d == WAIT);
        wb_stb_d    = (state_d == REQ);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rty_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= '0;
            wb_adr_q     <= '0;
            wb_dat_q     <= '0;
            wb_sel_q     <= '0;
            wb_we_q      <= 1'b0;
            wb_cyc_q     <= 1'b0;
            wb_stb_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rty_cnt_q    <= rty_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            wb_adr_q     <= wb_adr_d;
            wb_dat_q     <= wb_dat_d;
            wb_sel_q     <= wb_sel_d;
            wb_we_q      <= wb_we_d;
            wb_cyc_q     <= wb_cyc_d;
            wb_stb_q     <= wb_stb_d;
        end
    end

    assign bus.cmd_ready_o  = cmd_ready_q;
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_dat_o    = rsp_dat_q;
    assign bus.rsp_status_o = rsp_status_q;
    assign bus.wb_adr_o     = wb_adr_q;
    assign bus.wb_dat_o     = wb_dat_q;
    assign bus.wb_sel_o     = wb_sel_q;
    assign bus.wb_we_o      = wb_we_q;
    assign bus.wb_cyc_o     = wb_cyc_q;
    assign bus.wb_stb_o     = wb_stb_q;
endmodule
